// File: rtl/spm_arb_pkg.sv
// Shared definitions for the SpMV fetch arbiter: FSM state encoding,
// default geometry and a helper for index widths.
package spm_arb_pkg;

  localparam int SPM_ELE_W_DEF = 32;
  localparam int CHAN_NUM_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  // Index width for a channel count; never zero so a single channel still works.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spm_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping CHAN_NUM-1 -> 0.
module spm_rr_picker
  import spm_arb_pkg::*;
#(
  parameter int CHAN_NUM = CHAN_NUM_DEF,
  parameter int IDX_W    = idx_w(CHAN_NUM)
) (
  input  logic [CHAN_NUM-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [CHAN_NUM-1:0] grant,
  output logic [IDX_W-1:0]    idx,
  output logic                any
);

  // Walk the channels starting at ptr; the first hit wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      j = int'(ptr) + i;
      if (j >= CHAN_NUM) j = j - CHAN_NUM;
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spm_fetch_arbiter.sv
// Shares one memory read port between CHAN_NUM SpMV channels. One
// outstanding request; the response triple is registered and broadcast,
// with a one-cycle stall bubble cleared only for the granted channel.
// Optional: define SPM_FETCH_ARB_PERF_EN to add saturating perf counters
// (perf_grant_cnt, perf_stall_cnt).
module spm_fetch_arbiter
  import spm_arb_pkg::*;
#(
  parameter int SPM_ELE_W = SPM_ELE_W_DEF,
  parameter int CHAN_NUM  = CHAN_NUM_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHAN_NUM-1:0]           chan_req,
  input  logic [CHAN_NUM*SPM_ELE_W-1:0] chan_addr,
  output logic                          mem_req_valid,
  output logic [SPM_ELE_W-1:0]          mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [SPM_ELE_W-1:0]          mem_resp_val,
  input  logic [SPM_ELE_W-1:0]          mem_resp_row_len,
  input  logic [SPM_ELE_W-1:0]          mem_resp_col_idx,
  output logic [SPM_ELE_W-1:0]          spm_val,
  output logic [SPM_ELE_W-1:0]          spm_row_len,
  output logic [SPM_ELE_W-1:0]          spm_col_idx,
  output logic [CHAN_NUM-1:0]           spm_fetch_stall,
  output logic [CHAN_NUM-1:0]           grant_onehot,
  output logic                          busy
`ifdef SPM_FETCH_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_grant_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int IDX_W = idx_w(CHAN_NUM);

  arb_state_e                         state_q, state_d;
  logic [IDX_W-1:0]                   rr_ptr_q;
  logic [IDX_W-1:0]                   grant_idx_q;
  logic [CHAN_NUM-1:0]                grant_q;
  logic [SPM_ELE_W-1:0]               addr_q;
  logic [CHAN_NUM-1:0][SPM_ELE_W-1:0] addr_arr;

  logic [CHAN_NUM-1:0] pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                take;
  logic                deliver;

  assign addr_arr = chan_addr;

  spm_rr_picker #(
    .CHAN_NUM (CHAN_NUM),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req   (chan_req),
    .ptr   (rr_ptr_q),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A new grant can only be taken in IDLE; data is delivered only from
  // WAIT_RESP, so responses seen in other states are dropped.
  assign take          = (state_q == IDLE) && pick_any;
  assign deliver       = (state_q == WAIT_RESP) && mem_resp_valid;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = addr_q;
  assign busy          = (state_q != IDLE);
  assign grant_onehot  = busy ? grant_q : '0;

  // Next-state logic for the single-outstanding-request FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick_any)       state_d = ISSUE;
      ISSUE:     if (mem_req_ready)  state_d = WAIT_RESP;
      WAIT_RESP: if (mem_resp_valid) state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the grant and its address at selection time so later changes
  // on chan_addr / chan_req cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_idx_q <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
    end else if (take) begin
      grant_idx_q <= pick_idx;
      grant_q     <= pick_onehot;
      addr_q      <= addr_arr[pick_idx];
    end
  end

  // Register the response triple and advance the round-robin pointer
  // past the channel just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      spm_val     <= '0;
      spm_row_len <= '0;
      spm_col_idx <= '0;
      rr_ptr_q    <= '0;
    end else if (deliver) begin
      spm_val     <= mem_resp_val;
      spm_row_len <= mem_resp_row_len;
      spm_col_idx <= mem_resp_col_idx;
      rr_ptr_q    <= (grant_idx_q == IDX_W'(CHAN_NUM - 1)) ? '0 : grant_idx_q + 1'b1;
    end
  end

  // Per-channel stall: low for exactly the cycle after delivery, and only
  // for the owner of the transaction.
  for (genvar i = 0; i < CHAN_NUM; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) spm_fetch_stall[i] <= 1'b1;
      else     spm_fetch_stall[i] <= ~(deliver && grant_q[i]);
    end
  end

`ifdef SPM_FETCH_ARB_PERF_EN
  // Saturating counters: delivered triples, and ISSUE cycles lost to backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (deliver && (perf_grant_cnt != '1))
        perf_grant_cnt <= perf_grant_cnt + 32'd1;
      if ((state_q == ISSUE) && !mem_req_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spm_fetch_arbiter.sv
// Directed bench for spm_fetch_arbiter (default 16 channels x 32 bits).
module tb_spm_fetch_arbiter;

  localparam int W = 32;
  localparam int N = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     chan_req;
  logic [N*W-1:0]   chan_addr;
  logic             mem_req_valid;
  logic [W-1:0]     mem_req_addr;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic [W-1:0]     mem_resp_val, mem_resp_row_len, mem_resp_col_idx;
  logic [W-1:0]     spm_val, spm_row_len, spm_col_idx;
  logic [N-1:0]     spm_fetch_stall;
  logic [N-1:0]     grant_onehot;
  logic             busy;
`ifdef SPM_FETCH_ARB_PERF_EN
  logic [31:0]      perf_grant_cnt, perf_stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  spm_fetch_arbiter #(.SPM_ELE_W(W), .CHAN_NUM(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .chan_req         (chan_req),
    .chan_addr        (chan_addr),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_ready    (mem_req_ready),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_row_len (mem_resp_row_len),
    .mem_resp_col_idx (mem_resp_col_idx),
    .spm_val          (spm_val),
    .spm_row_len      (spm_row_len),
    .spm_col_idx      (spm_col_idx),
    .spm_fetch_stall  (spm_fetch_stall),
    .grant_onehot     (grant_onehot),
    .busy             (busy)
`ifdef SPM_FETCH_ARB_PERF_EN
    ,
    .perf_grant_cnt   (perf_grant_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the issue, check the owner, accept, respond, check delivery.
  // next_req is applied with the response so the delivery cycle sees it.
  task automatic run_txn(input int exp_ch, input logic [W-1:0] v, input logic [N-1:0] next_req);
    int n;
    logic [N-1:0] exp_stall;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("issue_seen", 64'(n < 20), 64'd1);
    chk("grant", 64'(grant_onehot), 64'(16'd1 << exp_ch));
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_val   = v;
    chan_req       = next_req;
    tick();
    mem_resp_valid = 1'b0;
    exp_stall = 16'hFFFF ^ (16'd1 << exp_ch);
    chk("deliver_stall", 64'(spm_fetch_stall), 64'(exp_stall));
    chk("deliver_val", 64'(spm_val), 64'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; chan_req = '0; chan_addr = '0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_val = '0; mem_resp_row_len = '0; mem_resp_col_idx = '0;
    tick(); tick();
    // reset state
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_addr",  64'(mem_req_addr), 64'd0);
    chk("rst_stall", 64'(spm_fetch_stall), 64'hFFFF);
    chk("rst_grant", 64'(grant_onehot), 64'd0);
    chk("rst_val",   64'(spm_val), 64'd0);
`ifdef SPM_FETCH_ARB_PERF_EN
    chk("rst_pgrant", 64'(perf_grant_cnt), 64'd0);
    chk("rst_pstall", 64'(perf_stall_cnt), 64'd0);
`endif
    rst = 1'b0;

    // fairness: all channels requesting, 32 transactions in order
    for (int i = 0; i < N; i++) chan_addr[i*W +: W] = W'(32'h1000 + i * 16);
    chan_req = 16'hFFFF;
    for (int k = 0; k < 32; k++)
      run_txn(k % N, W'(32'h100 + k), (k == 31) ? 16'h0000 : 16'hFFFF);
    tick();
    chk("idle_after_fair", 64'(busy), 64'd0);

    // single request on channel 2 with a 3-cycle response
    chan_req = 16'h0004;
    chan_addr[2*W +: W] = 32'h100;
    tick();
    chk("sr_valid", 64'(mem_req_valid), 64'd1);
    chk("sr_addr",  64'(mem_req_addr), 64'h100);
    chk("sr_grant", 64'(grant_onehot), 64'h0004);
    chan_req = 16'h0000;                 // owner drops its request mid-flight
    chan_addr[2*W +: W] = 32'h999;       // and changes its address
    tick();
    chk("sr_wait_valid", 64'(mem_req_valid), 64'd0);
    chk("sr_wait_busy",  64'(busy), 64'd1);
    chk("sr_wait_addr",  64'(mem_req_addr), 64'h100);
    tick();
    chk("sr_wait_stall", 64'(spm_fetch_stall), 64'hFFFF);
    mem_resp_valid = 1'b1; mem_resp_val = 32'd7; mem_resp_row_len = 32'd3; mem_resp_col_idx = 32'd9;
    tick();
    mem_resp_valid = 1'b0;
    chk("sr_stall", 64'(spm_fetch_stall), 64'hFFFB);
    chk("sr_val",   64'(spm_val), 64'd7);
    chk("sr_row",   64'(spm_row_len), 64'd3);
    chk("sr_col",   64'(spm_col_idx), 64'd9);
    chk("sr_idle",  64'(grant_onehot), 64'd0);
    tick();
    chk("sr_stall_after", 64'(spm_fetch_stall), 64'hFFFF);
    chk("sr_val_hold",    64'(spm_val), 64'd7);

    // wrap: serve 14 so the pointer sits at 15, then 0x8001 -> 15 then 0
    chan_req = 16'h4000;
    run_txn(14, 32'h14, 16'h8001);
    run_txn(15, 32'h15, 16'h8001);
    run_txn(0,  32'h16, 16'h0000);
    tick();

    // backpressure on channel 4, with stray responses during ISSUE
    chan_req = 16'h0010;
    chan_addr[4*W +: W] = 32'h4440;
    mem_req_ready = 1'b0;
    tick();
    chan_req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(mem_req_valid), 64'd1);
      chk("bp_addr",  64'(mem_req_addr), 64'h4440);
      chk("bp_stall", 64'(spm_fetch_stall), 64'hFFFF);
      chan_addr[4*W +: W] = W'(32'h1234 + i);
      mem_resp_valid = 1'b1; mem_resp_val = 32'hBAD;
      tick();
    end
    mem_resp_valid = 1'b0;
    chk("bp_still_issue", 64'(mem_req_valid), 64'd1);
    chk("bp_val_unchanged", 64'(spm_val), 64'h16);
`ifdef SPM_FETCH_ARB_PERF_EN
    chk("bp_perf_stall", 64'(perf_stall_cnt), 64'd5);
`endif
    mem_req_ready = 1'b1;
    tick();
    mem_resp_valid = 1'b1; mem_resp_val = 32'h55;
    tick();
    mem_resp_valid = 1'b0;
    chk("bp_deliver_stall", 64'(spm_fetch_stall), 64'hFFEF);
    chk("bp_deliver_val",   64'(spm_val), 64'h55);
`ifdef SPM_FETCH_ARB_PERF_EN
    chk("perf_grant", 64'(perf_grant_cnt), 64'd37);
`endif
    tick();

    // abort: reset in WAIT_RESP on channel 5, then a stray response
    chan_req = 16'h0020;
    tick();
    chan_req = 16'h0000;
    tick();
    chk("ab_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("ab_busy_rst",  64'(busy), 64'd0);
    chk("ab_stall_rst", 64'(spm_fetch_stall), 64'hFFFF);
    chk("ab_val_rst",   64'(spm_val), 64'd0);
    chk("ab_grant_rst", 64'(grant_onehot), 64'd0);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_val = 32'h77;
    tick();
    chk("ab_stray_stall", 64'(spm_fetch_stall), 64'hFFFF);
    tick();
    mem_resp_valid = 1'b0;
    chk("ab_stray_stall2", 64'(spm_fetch_stall), 64'hFFFF);
    chk("ab_stray_val",    64'(spm_val), 64'd0);
    // pointer back at 0 after reset
    chan_req = 16'hFFFF;
    run_txn(0, 32'hA, 16'h0000);
    tick();

    // spurious response while IDLE
    mem_resp_valid = 1'b1; mem_resp_val = 32'hDEAD;
    tick();
    chk("sp_stall", 64'(spm_fetch_stall), 64'hFFFF);
    chk("sp_val",   64'(spm_val), 64'hA);
    chk("sp_busy",  64'(busy), 64'd0);
    mem_resp_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spm_fetch_arbiter.md
SPM_FETCH_ARBITER -- requirements
Module: spm_fetch_arbiter

Interface
REQ-001 Parameter SPM_ELE_W, default 32: width of the matrix value, row length, column index and address words.
REQ-002 Parameter CHAN_NUM, default 16: number of SpMV channels sharing one memory read port.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 chan_req  input  CHAN_NUM  per-channel fetch request, level.
REQ-006 chan_addr  input  CHAN_NUM*SPM_ELE_W  per-channel fetch address, flattened; channel i occupies bits [i*SPM_ELE_W +: SPM_ELE_W].
REQ-007 mem_req_valid / mem_req_addr  output  1 / SPM_ELE_W  memory read request.
REQ-008 mem_req_ready  input  1  memory accepts the request.
REQ-009 mem_resp_valid  input  1  response strobe for the single outstanding request.
REQ-010 mem_resp_val / mem_resp_row_len / mem_resp_col_idx  input  SPM_ELE_W each  response triple.
REQ-011 spm_val / spm_row_len / spm_col_idx  output  SPM_ELE_W each  registered triple, broadcast to all channels.
REQ-012 spm_fetch_stall  output  CHAN_NUM  per-channel bubble; low means the triple is valid for that channel this cycle.
REQ-013 grant_onehot  output  CHAN_NUM  channel owning the current transaction; zero in IDLE.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_RESP; at most one outstanding memory request.
REQ-016 IDLE: if chan_req != 0, select the first requester at or after rr_ptr (round-robin, wrapping CHAN_NUM-1 -> 0), latch its index and address, and enter ISSUE; otherwise remain in IDLE.
REQ-017 ISSUE: mem_req_valid=1, with mem_req_addr holding the latched address stable; on mem_req_valid && mem_req_ready, enter WAIT_RESP.
REQ-018 WAIT_RESP: on mem_resp_valid, register the triple into spm_* outputs, clear the stall bit of the granted channel for the following cycle only, set rr_ptr to grant+1 (mod CHAN_NUM), and enter IDLE.
REQ-019 The latency from a request seen in IDLE at cycle t with ready=1 and response at t+k is: mem_req_valid at t+1 and stall low at t+k+1.
REQ-020 The arbiter SHALL issue back-to-back transactions: the cycle that delivers data is an IDLE cycle that may make a new grant.
REQ-021 Outside the single delivery cycle, all spm_fetch_stall bits SHALL be 1; spm_* outputs hold their last value.
REQ-022 A mem_resp_valid arriving in IDLE or ISSUE SHALL be ignored.
REQ-023 If the granted channel drops chan_req mid-transaction, the transaction SHALL complete and deliver normally.
REQ-024 Changes to chan_addr after the grant SHALL not affect mem_req_addr.

Reset
REQ-025 While rst=1 (synchronous, active-high): state=IDLE; rr_ptr=0; mem_req_valid=0; mem_req_addr=0; spm_*=0; spm_fetch_stall all 1; grant_onehot=0; busy=0; perf counters=0.
REQ-026 Reset asserted mid-transaction SHALL abandon it, with no delivery, and any later response SHALL be ignored per REQ-022.

Configuration
REQ-027 With macro SPM_FETCH_ARB_PERF_EN defined, the block SHALL add outputs perf_grant_cnt (32 bits, +1 per delivered triple) and perf_stall_cnt (32 bits, +1 per cycle in ISSUE with mem_req_ready=0), both saturating at all-ones.
REQ-028 Without SPM_FETCH_ARB_PERF_EN, these ports and counters SHALL not exist, and behaviour is otherwise identical.

Structure
REQ-029 Shared package spm_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE, WAIT_RESP) and the default SPM_ELE_W and CHAN_NUM constants.
REQ-030 The round-robin selection SHALL be a combinational sub-module spm_rr_picker (inputs req vector and pointer; outputs one-hot grant, index and any-valid).

Verification
REQ-031 Single request: chan_req=0x0004, addr=0x100, ready=1, response 3 cycles later with val=7 -> mem_req_addr=0x100; spm_fetch_stall=0xFFFB for exactly one cycle, with spm_val=7.
REQ-032 Fairness: chan_req=0xFFFF held for 32 transactions -> grants 0,1,...,15,0,...,15 in order.
REQ-033 Wrap: rr_ptr=15 with chan_req=0x8001 -> grant 15, then grant 0.
REQ-034 Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and the address stay stable; with PERF_EN, perf_stall_cnt=5.
REQ-035 Abort: rst=1 asserted in WAIT_RESP, then a stray mem_resp_valid -> all stalls stay 1, spm_val=0, rr_ptr=0.
REQ-036 Spurious response: mem_resp_valid in IDLE -> no stall bit drops and the outputs are unchanged.
